// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup and MEM-stage training bundle for the branch predictor
interface branch_predictor_if;
    logic [31:0] if_pc;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_branch;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_is_branch, upd_is_jump,
               upd_taken, upd_target, upd_mispredict,
        input  predict_taken, predict_target
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_is_branch, upd_is_jump,
               upd_taken, upd_target, upd_mispredict,
        output predict_taken, predict_target
    );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters and post-reset clear sweep
module branch_predictor #(
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_predictor_if.slave    bp,
    output logic                 ready,
    output logic [15:0]          mispredict_count
);
    localparam int INDEX_BITS = $clog2(ENTRIES);

    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_next;

    logic [INDEX_BITS-1:0] sweep_idx;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];

    logic [INDEX_BITS-1:0] rd_idx, wr_idx;
    logic [TAG_BITS-1:0]   rd_tag, wr_tag;
    logic                  rd_hit, wr_hit;
    logic                  accept, upd_en;
    logic [1:0]            ctr_sat;

    // PC bit 0 and bits above the tag never reach the table
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.if_pc[0], bp.if_pc[31:INDEX_BITS+TAG_BITS+1],
                              bp.upd_pc[0], bp.upd_pc[31:INDEX_BITS+TAG_BITS+1]};

    assign rd_idx = bp.if_pc[INDEX_BITS:1];
    assign rd_tag = bp.if_pc[INDEX_BITS+TAG_BITS:INDEX_BITS+1];
    assign wr_idx = bp.upd_pc[INDEX_BITS:1];
    assign wr_tag = bp.upd_pc[INDEX_BITS+TAG_BITS:INDEX_BITS+1];

    assign ready  = (state == RUN);
    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    assign bp.predict_taken  = ready && rd_hit && ctr_q[rd_idx][1];
    assign bp.predict_target = bp.predict_taken ? target_q[rd_idx] : 32'd0;

    assign accept = (state == RUN) && bp.upd_valid;
    assign upd_en = accept && (bp.upd_is_branch || bp.upd_is_jump);

    always_comb begin
        ctr_sat = ctr_q[wr_idx];
        if (bp.upd_taken) begin
            if (ctr_q[wr_idx] != 2'd3) ctr_sat = ctr_q[wr_idx] + 2'd1;
        end else begin
            if (ctr_q[wr_idx] != 2'd0) ctr_sat = ctr_q[wr_idx] - 2'd1;
        end
    end

    always_comb begin
        state_next = state;
        if (state == INIT && sweep_idx == INDEX_BITS'(ENTRIES - 1)) state_next = RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            sweep_idx <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) sweep_idx <= sweep_idx + 1'b1;
        end
    end

    // Table writes: sweep clears during INIT, training writes during RUN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                valid_q[sweep_idx] <= 1'b0;
            end else if (upd_en) begin
                if (wr_hit) begin
                    ctr_q[wr_idx] <= bp.upd_is_jump ? 2'd3 : ctr_sat;
                    if (bp.upd_taken || bp.upd_is_jump) target_q[wr_idx] <= bp.upd_target;
                end else if (bp.upd_is_jump || bp.upd_taken) begin
                    valid_q[wr_idx]  <= 1'b1;
                    tag_q[wr_idx]    <= wr_tag;
                    ctr_q[wr_idx]    <= bp.upd_is_jump ? 2'd3 : 2'd2;
                    target_q[wr_idx] <= bp.upd_target;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict_count <= 16'd0;
        end else if (accept && bp.upd_mispredict && mispredict_count != 16'hFFFF) begin
            mispredict_count <= mispredict_count + 16'd1;
        end
    end
endmodule
